// File: rtl/ring_buffer_reader.sv
// ring_buffer_reader: drains a circular buffer through a 1-cycle-latency RAM
// and presents each word on a valid/ready output port.
module ring_buffer_reader #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PW-1:0]         wr_ptr,
    input  logic                  flush,
    output logic [PW-1:0]         rd_ptr,
    output logic                  mem_rd_en,
    output logic [PW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic [PW-1:0]         level
);

    localparam logic [PW:0]   DEPTH_X = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    rd_en_c;
    logic                    empty_c;
    logic [PW-1:0]           rd_ptr_inc_c;
    logic [PW:0]             wr_ext_c, rd_ext_c;

    // Occupancy and wrap-aware pointer increment
    always_comb begin
        empty_c      = (rd_ptr_q == wr_ptr);
        rd_ptr_inc_c = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        wr_ext_c     = {1'b0, wr_ptr};
        rd_ext_c     = {1'b0, rd_ptr_q};
        if (wr_ptr >= rd_ptr_q) begin
            level = wr_ptr - rd_ptr_q;
        end else begin
            level = PW'(wr_ext_c + DEPTH_X - rd_ext_c);
        end
    end

    // Next-state, fetch strobe and output-word update
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        rd_en_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_valid_d = 1'b0;
                if (!empty_c) begin
                    rd_en_c  = 1'b1;
                    rd_ptr_d = rd_ptr_inc_c;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                data_out_d   = mem_data;
                data_valid_d = 1'b1;
                state_d      = VALID;
            end
            VALID: begin
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    if (!empty_c) begin
                        rd_en_c  = 1'b1;
                        rd_ptr_d = rd_ptr_inc_c;
                        state_d  = FETCH;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                data_valid_d = 1'b0;
            end
        endcase

        // Flush discards unread and in-flight data, resyncing to the writer
        if (flush) begin
            rd_en_c      = 1'b0;
            rd_ptr_d     = wr_ptr;
            data_valid_d = 1'b0;
            state_d      = IDLE;
        end

        if (reset) begin
            rd_en_c = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign rd_ptr     = rd_ptr_q;
    assign mem_addr   = rd_ptr_q;
    assign mem_rd_en  = rd_en_c;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: doc/ring_buffer_reader.md
RING_BUFFER_READER -- requirements
Module: ring_buffer_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of ring-buffer entries (>= 2, need not be a power of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of one buffer entry.
REQ-003 SHALL define PW = $clog2(DEPTH) as the pointer width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_ptr  input  PW  writer's next-write index, wraps DEPTH-1 -> 0.
REQ-007 SHALL have port flush  input  1  discard all unread and in-flight data.
REQ-008 SHALL have port rd_ptr  output  PW  next index to be fetched, returned to the writer for full detection.
REQ-009 SHALL have port mem_rd_en  output  1  read strobe to the synchronous buffer RAM.
REQ-010 SHALL have port mem_addr  output  PW  RAM read address, always equal to rd_ptr.
REQ-011 SHALL have port mem_data  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  output word.
REQ-013 SHALL have port data_valid  output  1  data_out holds an untransferred word.
REQ-014 SHALL have port data_ready  input  1  consumer accepts data_out this cycle.
REQ-015 SHALL have port level  output  PW  number of written entries not yet fetched.

Function
REQ-016 SHALL treat the buffer as empty when rd_ptr == wr_ptr; the writer keeps at most DEPTH-1 entries outstanding, so this state is never a full buffer.
REQ-017 SHALL compute level combinationally: wr_ptr - rd_ptr if wr_ptr >= rd_ptr, else wr_ptr + DEPTH - rd_ptr, with no overflow at PW bits.
REQ-018 SHALL implement states IDLE, FETCH and VALID.
REQ-019 IDLE: data_valid = 0; if not empty, SHALL assert mem_rd_en, advance rd_ptr and go to FETCH; otherwise stay in IDLE.
REQ-020 FETCH: SHALL register mem_data into data_out, assert data_valid from the next cycle and go to VALID; mem_rd_en = 0.
REQ-021 VALID: data_out and data_valid SHALL stay stable while data_ready = 0.
REQ-022 VALID with data_ready = 1 and not empty: SHALL complete the transfer, assert mem_rd_en, advance rd_ptr and go to FETCH.
REQ-023 VALID with data_ready = 1 and empty: SHALL complete the transfer and go to IDLE.
REQ-024 A transfer occurs only on a cycle with data_valid = 1 and data_ready = 1; data_valid SHALL deassert the cycle after a transfer unless a new word is registered that same edge (never, per REQ-020/022).
REQ-025 SHALL give latency from a non-empty IDLE to data_valid = 1 of exactly 2 cycles and a sustained throughput of 1 word per 2 cycles.
REQ-026 rd_ptr advance SHALL wrap: DEPTH-1 -> 0, otherwise +1.
REQ-027 mem_rd_en SHALL assert only when the buffer is non-empty in that cycle.
REQ-028 flush = 1 SHALL, at the next edge, set rd_ptr <= wr_ptr, clear data_valid, discard any in-flight read and go to IDLE; mem_rd_en = 0 during flush.
REQ-029 flush SHALL take priority over every state transition; reset SHALL take priority over flush.
REQ-030 wr_ptr changing in the same cycle as a fetch decision SHALL use the current-cycle wr_ptr value only.

Reset
REQ-031 reset = 1 SHALL, at the next edge, set state IDLE, rd_ptr = 0, data_out = 0 and data_valid = 0; mem_rd_en = 0 while reset is high.
REQ-032 Reset asserted mid-FETCH or mid-VALID SHALL drop the word with no transfer, and it SHALL take effect regardless of data_ready.
REQ-033 The writer SHALL also restart at 0; level reads 0 on the first cycle after reset when wr_ptr = 0.

Verification
REQ-034 Reset, wr_ptr 0 -> 3, data_ready = 1, RAM[0..2] = 0xA0, 0xA1, 0xA2 -> words A0, A1, A2 out in order, 2 cycles apart; then IDLE with rd_ptr = 3 and level = 0.
REQ-035 DEPTH = 256, rd_ptr = 254, wr_ptr = 2 -> level = 4; fetches from addresses 254, 255, 0, 1; rd_ptr ends at 2.
REQ-036 data_ready = 0 for 5 cycles while VALID -> data_out is unchanged, no mem_rd_en, rd_ptr is frozen; data_ready = 1 -> one transfer.
REQ-037 flush during FETCH with wr_ptr = 9 -> next cycle data_valid = 0, rd_ptr = 9, IDLE; the fetched word never appears.
REQ-038 reset pulse during VALID with data_ready = 1 -> no transfer; rd_ptr = 0 and data_valid = 0 after the edge.
REQ-039 DEPTH = 5 (non power of two), write 7 words in two rounds -> rd_ptr wraps 4 -> 0; all words are returned in order.
